// File: rtl/lsu_pkg.sv
// lsu_pkg: shared state encoding and NByteOp size codes for the load/store unit.
package lsu_pkg;
   typedef enum logic [1:0] {IDLE, REQ, DONE} lsu_state_t;
   localparam logic [1:0] NB_WORD = 2'b00;
   localparam logic [1:0] NB_BYTE = 2'b01;
   localparam logic [1:0] NB_HALF = 2'b10;
   localparam logic [1:0] NB_ILL  = 2'b11;
endpackage

// File: rtl/lsu_align.sv
// lsu_align: combinational lane steering for stores and lane extraction/extension for loads.
module lsu_align
   import lsu_pkg::*;
(
   input  logic [1:0]  nbyte_op,
   input  logic [1:0]  off,
   input  logic        is_unsigned,
   input  logic [31:0] wdata,
   input  logic [31:0] rdata_word,
   output logic [3:0]  wstrb,
   output logic [31:0] wdata_rep,
   output logic        misaligned,
   output logic [31:0] rdata_ext
);
   logic [7:0]  lane_b;
   logic [15:0] lane_h;
   always_comb begin
      lane_b     = 8'(rdata_word >> {off, 3'b000});
      lane_h     = off[1] ? rdata_word[31:16] : rdata_word[15:0];
      misaligned = (nbyte_op == NB_WORD && off != 2'b00) || (nbyte_op == NB_HALF && off[0]);
      wstrb      = nbyte_op == NB_BYTE ? 4'b0001 << off :
                   nbyte_op == NB_HALF ? (off[1] ? 4'b1100 : 4'b0011) :
                   nbyte_op == NB_WORD ? 4'b1111 : 4'b0000;
      wdata_rep  = nbyte_op == NB_BYTE ? {4{wdata[7:0]}} :
                   nbyte_op == NB_HALF ? {2{wdata[15:0]}} : wdata;
      rdata_ext  = nbyte_op == NB_BYTE ? {{24{~is_unsigned & lane_b[7]}}, lane_b} :
                   nbyte_op == NB_HALF ? {{16{~is_unsigned & lane_h[15]}}, lane_h} : rdata_word;
   end
endmodule

// File: rtl/lsu.sv
// lsu: load/store unit FSM; captures the request, runs one req/ack bus transaction,
// and returns an extended load result or a fault on illegal/misaligned accesses.
module lsu
   import lsu_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              mem_read,
   input  logic              mem_write,
   input  logic [1:0]        nbyte_op,
   input  logic              is_unsigned,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] rdata,
   output logic              fault,
   output logic              bus_req,
   output logic              bus_we,
   output logic [ADDR_W-1:0] bus_addr,
   output logic [3:0]        bus_wstrb,
   output logic [DATA_W-1:0] bus_wdata,
   input  logic              bus_ack,
   input  logic [DATA_W-1:0] bus_rdata
);
   lsu_state_t        state_q, state_d;
   logic              rd_q, rd_d, wr_q, wr_d, uns_q, uns_d, fault_q, fault_d;
   logic [1:0]        nb_q, nb_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [3:0]        wstrb_q, wstrb_d;
   logic [DATA_W-1:0] wrep_q, wrep_d, rdata_q, rdata_d;
   logic [3:0]        a_wstrb;
   logic [31:0]       a_wrep, a_ext;
   logic              a_mis, idle, bad;

   assign idle = state_q == IDLE;

   // In IDLE the aligner sees the live request (fault check, store lanes); afterwards the captured one.
   lsu_align u_align (
      .nbyte_op   (idle ? nbyte_op : nb_q),
      .off        (idle ? addr[1:0] : addr_q[1:0]),
      .is_unsigned(uns_q),
      .wdata      (wdata),
      .rdata_word (bus_rdata),
      .wstrb      (a_wstrb),
      .wdata_rep  (a_wrep),
      .misaligned (a_mis),
      .rdata_ext  (a_ext)
   );

   assign bad = (mem_read | mem_write) & ((mem_read & mem_write) | nbyte_op == NB_ILL | a_mis);

   always_comb begin
      state_d = state_q;
      rd_d    = rd_q;
      wr_d    = wr_q;
      nb_d    = nb_q;
      uns_d   = uns_q;
      addr_d  = addr_q;
      wstrb_d = wstrb_q;
      wrep_d  = wrep_q;
      fault_d = fault_q;
      rdata_d = rdata_q;
      if (idle && start) begin
         rd_d    = mem_read;
         wr_d    = mem_write;
         nb_d    = nbyte_op;
         uns_d   = is_unsigned;
         addr_d  = addr;
         wstrb_d = mem_write ? a_wstrb : 4'b0000;
         wrep_d  = a_wrep;
         fault_d = bad;
         state_d = (bad || !(mem_read || mem_write)) ? DONE : REQ;
      end else if (state_q == REQ && bus_ack) begin
         rdata_d = rd_q ? a_ext : rdata_q;
         state_d = DONE;
      end else if (state_q == DONE) begin
         state_d = IDLE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         rd_q    <= 1'b0;
         wr_q    <= 1'b0;
         nb_q    <= NB_WORD;
         uns_q   <= 1'b0;
         addr_q  <= '0;
         wstrb_q <= 4'b0000;
         wrep_q  <= '0;
         fault_q <= 1'b0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         rd_q    <= rd_d;
         wr_q    <= wr_d;
         nb_q    <= nb_d;
         uns_q   <= uns_d;
         addr_q  <= addr_d;
         wstrb_q <= wstrb_d;
         wrep_q  <= wrep_d;
         fault_q <= fault_d;
         rdata_q <= rdata_d;
      end
   end

   assign busy      = state_q != IDLE;
   assign done      = state_q == DONE;
   assign bus_req   = state_q == REQ;
   assign bus_we    = wr_q;
   assign bus_addr  = {addr_q[ADDR_W-1:2], 2'b00};
   assign bus_wstrb = wstrb_q;
   assign bus_wdata = wrep_q;
   assign fault     = fault_q;
   assign rdata     = rdata_q;
endmodule

// File: tb/tb_lsu.sv
// tb_lsu: directed self-checking bench for lsu; cycle 0 is the cycle in which start is sampled.
module tb_lsu;
  import lsu_pkg::*;
  logic        clk = 0, rst_n = 0, start = 0, mem_read = 0, mem_write = 0, is_unsigned = 0;
  logic [1:0]  nbyte_op = 0;
  logic [31:0] addr = 0, wdata = 0, bus_rdata = 0;
  logic        bus_ack = 0;
  logic        busy, done, fault, bus_req, bus_we;
  logic [31:0] rdata, bus_addr, bus_wdata;
  logic [3:0]  bus_wstrb;
  int          n_checks = 0, n_fail = 0;

  lsu dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mem_read(mem_read), .mem_write(mem_write),
    .nbyte_op(nbyte_op), .is_unsigned(is_unsigned), .addr(addr), .wdata(wdata),
    .busy(busy), .done(done), .rdata(rdata), .fault(fault), .bus_req(bus_req),
    .bus_we(bus_we), .bus_addr(bus_addr), .bus_wstrb(bus_wstrb), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  task automatic issue(input logic rd, input logic wr, input logic [1:0] nb, input logic uns,
                       input logic [31:0] a, input logic [31:0] wd);
    mem_read = rd; mem_write = wr; nbyte_op = nb; is_unsigned = uns; addr = a; wdata = wd;
    start = 1;
    @(posedge clk); #1;
    start = 0; mem_read = ~rd; mem_write = ~wr; nbyte_op = ~nb; is_unsigned = ~uns;
    addr = 32'hFFFF_FFFF; wdata = 32'h5555_5555;
  endtask

  task automatic next_cycle;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst_n = 0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1;
    next_cycle();
    n_checks++;
    if ({busy, done, fault, bus_req, bus_we, bus_wstrb} !== 9'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b expected 0", {busy, done, fault, bus_req, bus_we, bus_wstrb});
    end
    n_checks++;
    if ({rdata, bus_addr, bus_wdata} !== 96'b0) begin
      n_fail++;
      $display("FAIL reset_data: got rdata=%h addr=%h wdata=%h expected 0", rdata, bus_addr, bus_wdata);
    end
  endtask

  task automatic test_lw;
    issue(1, 0, NB_WORD, 0, 32'h100, 32'h0);
    n_checks++;
    if ({bus_req, busy, done, bus_we, bus_wstrb, bus_addr} !== {4'b1100, 4'b0000, 32'h100}) begin
      n_fail++;
      $display("FAIL lw_req: got req=%b busy=%b done=%b we=%b strb=%b addr=%h expected 1 1 0 0 0000 00000100",
               bus_req, busy, done, bus_we, bus_wstrb, bus_addr);
    end
    bus_ack = 1; bus_rdata = 32'hDEADBEEF;
    next_cycle();
    bus_ack = 0; bus_rdata = 32'h0;
    n_checks++;
    if ({done, fault, bus_req, rdata} !== {3'b100, 32'hDEADBEEF}) begin
      n_fail++;
      $display("FAIL lw_done: got done=%b fault=%b req=%b rdata=%h expected 1 0 0 deadbeef", done, fault, bus_req, rdata);
    end
    next_cycle();
    n_checks++;
    if ({done, busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL lw_idle: got done=%b busy=%b expected 0 0", done, busy);
    end
  endtask

  task automatic test_loads;
    logic [1:0]  nbs[4];
    logic        unss[4];
    logic [31:0] as[4], exps[4];
    nbs  = '{NB_BYTE, NB_BYTE, NB_HALF, NB_HALF};
    unss = '{1'b0, 1'b1, 1'b0, 1'b1};
    as   = '{32'h103, 32'h103, 32'h102, 32'h102};
    exps = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h000080FF};
    for (int i = 0; i < 4; i++) begin
      issue(1, 0, nbs[i], unss[i], as[i], 32'h0);
      bus_ack = 1; bus_rdata = 32'h80FF_1234;
      next_cycle();
      bus_ack = 0;
      n_checks++;
      if ({done, fault, rdata} !== {2'b10, exps[i]}) begin
        n_fail++;
        $display("FAIL load_%0d: got done=%b fault=%b rdata=%h expected 1 0 %h", i, done, fault, rdata, exps[i]);
      end
      next_cycle();
    end
  endtask

  task automatic test_stores;
    issue(0, 1, NB_HALF, 0, 32'h202, 32'h0000ABCD);
    for (int c = 1; c <= 4; c++) begin
      n_checks++;
      if ({bus_req, bus_we, done, bus_wstrb, bus_addr, bus_wdata} !== {3'b110, 4'b1100, 32'h200, 32'hABCDABCD}) begin
        n_fail++;
        $display("FAIL sh_cycle%0d: got req=%b we=%b done=%b strb=%b addr=%h wdata=%h expected 1 1 0 1100 00000200 abcdabcd",
                 c, bus_req, bus_we, done, bus_wstrb, bus_addr, bus_wdata);
      end
      bus_ack = (c == 4);
      next_cycle();
    end
    bus_ack = 0;
    n_checks++;
    if ({done, fault, bus_req, rdata} !== {3'b100, 32'h000080FF}) begin
      n_fail++;
      $display("FAIL sh_done: got done=%b fault=%b req=%b rdata=%h expected 1 0 0 000080ff", done, fault, bus_req, rdata);
    end
    next_cycle();
    issue(0, 1, NB_BYTE, 0, 32'h101, 32'h1234_565A);
    n_checks++;
    if ({bus_wstrb, bus_wdata} !== {4'b0010, 32'h5A5A5A5A}) begin
      n_fail++;
      $display("FAIL sb_lanes: got strb=%b wdata=%h expected 0010 5a5a5a5a", bus_wstrb, bus_wdata);
    end
    bus_ack = 1; next_cycle(); bus_ack = 0; next_cycle();
    issue(0, 1, NB_WORD, 0, 32'h300, 32'h1234_5678);
    n_checks++;
    if ({bus_wstrb, bus_wdata, bus_addr} !== {4'b1111, 32'h12345678, 32'h300}) begin
      n_fail++;
      $display("FAIL sw_lanes: got strb=%b wdata=%h addr=%h expected 1111 12345678 00000300", bus_wstrb, bus_wdata, bus_addr);
    end
    bus_ack = 1; next_cycle(); bus_ack = 0; next_cycle();
  endtask

  task automatic test_faults;
    logic        rds[5], wrs[5], expf[5];
    logic [1:0]  nbs[5];
    logic [31:0] as[5];
    rds  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    wrs  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    nbs  = '{NB_WORD, NB_HALF, NB_ILL, NB_WORD, NB_WORD};
    as   = '{32'h101, 32'h203, 32'h100, 32'h100, 32'h100};
    expf = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 5; i++) begin
      bus_ack = 1; bus_rdata = 32'h0BAD_0BAD;
      issue(rds[i], wrs[i], nbs[i], 0, as[i], 32'hFFFF_FFFF);
      n_checks++;
      if ({done, fault, bus_req, rdata} !== {1'b1, expf[i], 1'b0, 32'h000080FF}) begin
        n_fail++;
        $display("FAIL fault_%0d: got done=%b fault=%b req=%b rdata=%h expected 1 %b 0 000080ff",
                 i, done, fault, bus_req, rdata, expf[i]);
      end
      next_cycle();
      n_checks++;
      if ({done, busy, bus_req, rdata} !== {3'b000, 32'h000080FF}) begin
        n_fail++;
        $display("FAIL fault_%0d_after: got done=%b busy=%b req=%b rdata=%h expected 0 0 0 000080ff",
                 i, done, busy, bus_req, rdata);
      end
      bus_ack = 0;
    end
  endtask

  task automatic test_ignore;
    issue(1, 0, NB_WORD, 0, 32'h104, 32'h0);
    mem_read = 1; nbyte_op = NB_WORD; addr = 32'h200; start = 1;
    next_cycle();
    start = 0;
    n_checks++;
    if ({bus_req, done, bus_addr} !== {2'b10, 32'h104}) begin
      n_fail++;
      $display("FAIL restart_req: got req=%b done=%b addr=%h expected 1 0 00000104", bus_req, done, bus_addr);
    end
    bus_ack = 1; bus_rdata = 32'h1122_3344;
    next_cycle();
    bus_ack = 0;
    n_checks++;
    if ({done, rdata} !== {1'b1, 32'h11223344}) begin
      n_fail++;
      $display("FAIL restart_done: got done=%b rdata=%h expected 1 11223344", done, rdata);
    end
    bus_ack = 1; bus_rdata = 32'h9999_9999;
    for (int c = 0; c < 3; c++) begin
      next_cycle();
      n_checks++;
      if ({done, busy, bus_req, rdata} !== {3'b000, 32'h11223344}) begin
        n_fail++;
        $display("FAIL stray_%0d: got done=%b busy=%b req=%b rdata=%h expected 0 0 0 11223344", c, done, busy, bus_req, rdata);
      end
    end
    bus_ack = 0;
  endtask

  task automatic test_async_reset;
    issue(1, 0, NB_WORD, 0, 32'h108, 32'h0);
    n_checks++;
    if (bus_req !== 1'b1) begin
      n_fail++;
      $display("FAIL arst_pre: got req=%b expected 1", bus_req);
    end
    #2 rst_n = 0;
    #1;
    n_checks++;
    if ({bus_req, busy, done, rdata} !== 35'b0) begin
      n_fail++;
      $display("FAIL arst_now: got req=%b busy=%b done=%b rdata=%h expected 0 0 0 00000000", bus_req, busy, done, rdata);
    end
    @(negedge clk) rst_n = 1;
    next_cycle();
    issue(1, 0, NB_WORD, 1, 32'h10C, 32'h0);
    next_cycle();
    bus_ack = 1; bus_rdata = 32'hCAFE_F00D;
    n_checks++;
    if ({bus_req, done, bus_addr} !== {2'b10, 32'h10C}) begin
      n_fail++;
      $display("FAIL arst_lw_req: got req=%b done=%b addr=%h expected 1 0 0000010c", bus_req, done, bus_addr);
    end
    next_cycle();
    bus_ack = 0;
    n_checks++;
    if ({done, fault, rdata} !== {2'b10, 32'hCAFEF00D}) begin
      n_fail++;
      $display("FAIL arst_lw_done: got done=%b fault=%b rdata=%h expected 1 0 cafef00d", done, fault, rdata);
    end
    next_cycle();
  endtask

  task automatic test_back_to_back;
    issue(0, 1, NB_WORD, 0, 32'h400, 32'hA5A5_0000);
    bus_ack = 1;
    next_cycle();
    bus_ack = 0;
    n_checks++;
    if ({done, fault, bus_we} !== 3'b101) begin
      n_fail++;
      $display("FAIL b2b_sw_done: got done=%b fault=%b we=%b expected 1 0 1", done, fault, bus_we);
    end
    next_cycle();
    issue(1, 0, NB_BYTE, 1, 32'h401, 32'h0);
    n_checks++;
    if ({bus_req, bus_we, bus_wstrb, bus_addr} !== {2'b10, 4'b0000, 32'h400}) begin
      n_fail++;
      $display("FAIL b2b_lbu_req: got req=%b we=%b strb=%b addr=%h expected 1 0 0000 00000400", bus_req, bus_we, bus_wstrb, bus_addr);
    end
    bus_ack = 1; bus_rdata = 32'h0000_AB00;
    next_cycle();
    bus_ack = 0;
    n_checks++;
    if ({done, rdata} !== {1'b1, 32'h000000AB}) begin
      n_fail++;
      $display("FAIL b2b_lbu_done: got done=%b rdata=%h expected 1 000000ab", done, rdata);
    end
    next_cycle();
  endtask

  initial begin
    test_reset();
    test_lw();
    test_loads();
    test_stores();
    test_faults();
    test_ignore();
    test_async_reset();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/lsu.md
# lsu

Load/store unit for the rv32e core. It consumes the memory-side decode from the control stage (`MemRead`, `MemWrite`, `NByteOp`, `Unsigned`) together with the ALU-computed address and rs2 data. It runs one request/acknowledge transaction on the data bus and returns an aligned, sign- or zero-extended load result, or a fault for misaligned or illegal accesses. The pipeline stalls on `busy` and resumes on the `done` pulse.

## Interface
Parameters:
- `ADDR_W`, 32, byte-address width of `addr` and `bus_addr`.
- `DATA_W`, 32, data width. Fixed at 32; any other value is unsupported.

Ports:
- `clk`  in  1  core clock; everything is rising-edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  request strobe; sampled only in IDLE.
- `mem_read`  in  1  load request (control `MemRead`).
- `mem_write`  in  1  store request (control `MemWrite`).
- `nbyte_op`  in  2  access size: 00 word, 01 byte, 10 half, 11 illegal (control `NByteOp`).
- `is_unsigned`  in  1  zero-extend loads (control `Unsigned`).
- `addr`  in  ADDR_W  effective byte address (ALU result).
- `wdata`  in  32  store data (rs2).
- `busy`  out  1  high from the cycle after `start` is accepted through the `done` cycle.
- `done`  out  1  one-cycle completion pulse.
- `rdata`  out  32  extended load result. Valid with `done`; held until the next `done`.
- `fault`  out  1  valid with `done`: misaligned access, `nbyte_op==11`, or `mem_read&&mem_write`.
- `bus_req`  out  1  bus request; held high until ack.
- `bus_we`  out  1  1 = store.
- `bus_addr`  out  ADDR_W  word-aligned address `{addr[ADDR_W-1:2],2'b00}`.
- `bus_wstrb`  out  4  byte-lane write enables; 0000 on loads.
- `bus_wdata`  out  32  lane-replicated store data.
- `bus_ack`  in  1  completion from memory; may arrive in the same cycle as `bus_req`.
- `bus_rdata`  in  32  word read data; valid with `bus_ack`.

## Operation
- States: IDLE, REQ, DONE.
- IDLE, `start`=1:
  - Capture `mem_read`, `mem_write`, `nbyte_op`, `is_unsigned`, `addr`, `wdata` into registers. Inputs may change afterwards.
  - If the access is illegal, go to DONE with fault=1; no bus activity.
  - If `mem_read` and `mem_write` are both 0, go to DONE with fault=0 (no-op).
  - Otherwise go to REQ.
- REQ: `bus_req`=1 with stable `bus_*` outputs. On `bus_ack`=1, latch the extended load data (loads only) and go to DONE.
- DONE: `done`=1 for one cycle, then return to IDLE.
- `start` outside IDLE is ignored. `bus_ack` outside REQ is ignored.
- Alignment rules on `off=addr[1:0]`:
  - Word requires off==0.
  - Half requires off[0]==0.
  - Byte accepts any offset.
- Store lanes:
  - Byte: `wstrb=4'b0001<<off`, `bus_wdata={4{wdata[7:0]}}`.
  - Half: `wstrb` = 0011 (off 0) or 1100 (off 2), `bus_wdata={2{wdata[15:0]}}`.
  - Word: `wstrb`=1111, `bus_wdata=wdata`.
- Load extract:
  - Byte lane `bus_rdata[8*off+:8]`; half lane `bus_rdata[16*off[1]+:16]`.
  - Sign-extend unless `is_unsigned`. Word loads ignore `is_unsigned`.
- A faulted or no-op transaction leaves `rdata` unchanged.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `fault`=0, `rdata`=0, `bus_req`=0, `bus_we`=0, `bus_addr`=0, `bus_wstrb`=0, `bus_wdata`=0.
- Reset asserted mid-REQ drops `bus_req` immediately (asynchronous). The bus must tolerate the abandoned request.
- Legal access, `start` at cycle 0, `bus_ack` in cycle k≥1:
  - `bus_req` high in cycles 1..k.
  - `done` and `rdata` in cycle k+1.
  - Minimum latency start→done is 2 cycles.
- Fault or no-op: `done` in cycle 1, `bus_req` never asserted.
- `busy` equals (state != IDLE). Back-to-back: `start` may be accepted in the cycle after `done`.
- All outputs are registered or decoded from registered state only. There is no combinational path from `bus_ack`/`bus_rdata` to any output.

## Structure
- Package `lsu_pkg`:
  - `lsu_state_t` enum (IDLE, REQ, DONE).
  - NByteOp constants `NB_WORD=2'b00`, `NB_BYTE=2'b01`, `NB_HALF=2'b10`, `NB_ILL=2'b11`. The control stage imports the same constants.
- Sub-module `lsu_align`, purely combinational:
  - Store side: (nbyte_op, off, wdata) → (wstrb, wdata_rep, misaligned).
  - Load side: (nbyte_op, off, is_unsigned, rdata_word) → rdata_ext.
  - `lsu` instantiates it once and keeps only the FSM and the capture registers.

## Test plan
- lw, addr 0x100, ack at cycle 1, `bus_rdata`=0xDEADBEEF → `bus_addr`=0x100, `wstrb`=0000, `done` at cycle 2, `rdata`=0xDEADBEEF, fault=0.
- lb at 0x103 and lbu at 0x103, `bus_rdata`=0x80FF_1234 → `rdata` = 0xFFFFFF80 (lb) and 0x00000080 (lbu).
- sh at 0x202, `wdata`=0x0000ABCD, ack delayed 3 cycles → `bus_req` high in cycles 1-4, `wstrb`=1100, `bus_wdata`=0xABCDABCD, `done` at cycle 5.
- lw at 0x101; sh at 0x203; `nbyte_op`=11; read and write both set → each: fault=1, `done` at cycle 1, `bus_req` never asserted, `rdata` unchanged.
- `start` re-pulsed during REQ, stray `bus_ack` in IDLE → no extra transaction, no extra `done`.
- `rst_n` low during REQ → `bus_req`, `busy`, `done` are 0 the same cycle. After release, a new lw completes normally.
